// File: rtl/receiveword.sv
// Pulse-width word receiver: synchronises the serial line, measures each high
// pulse, decodes a 2-bit word MSB-first and strobes valid (or error) for one cycle.
//
// state | meaning
// IDLE  | line quiet, waiting for the first rising edge of a frame
// HIGH  | measuring a high pulse
// LOW   | measuring the gap between the two pulses of a frame
// STUCK | pulse exceeded the maximum width; waiting for the line to fall
module receiveword #(
  parameter int UNIT_CYCLES = 50000,
  parameter int CNT_W       = 20
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       in,
  output logic [1:0] word,
  output logic       valid,
  output logic       busy,
  output logic       error
);

  localparam logic [CNT_W-1:0] HALF_U  = CNT_W'(UNIT_CYCLES / 2);
  localparam logic [CNT_W-1:0] TWO_U   = CNT_W'(2 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] THREE_U = CNT_W'(3 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] FOUR_U  = CNT_W'(4 * UNIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_STUCK
  } state_e;

  logic             in_s1_q, in_s2_q, in_s3_q;
  logic             rise, fall;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             bit_idx_q, bit_idx_d;
  logic             shadow_q, shadow_d;
  logic [1:0]       word_q, word_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;
  logic             pulse_bit;

  // Two-flop synchroniser plus a third copy for edge detection.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      in_s1_q <= 1'b0;
      in_s2_q <= 1'b0;
      in_s3_q <= 1'b0;
    end else begin
      in_s1_q <= in;
      in_s2_q <= in_s1_q;
      in_s3_q <= in_s2_q;
    end
  end

  assign rise = in_s2_q & ~in_s3_q;
  assign fall = ~in_s2_q & in_s3_q;

  // Counter never wraps, so a very long pulse or gap cannot alias to a short one.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  // The count seen at the falling edge is the pulse width in cycles minus one:
  // the counter is cleared in the cycle the rise is seen and stops being looked
  // at in the cycle the fall is seen.
  assign pulse_bit = (cnt_q >= TWO_U);

  // Next-state, counter and output-strobe decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_inc;
    bit_idx_d = bit_idx_q;
    shadow_d  = shadow_q;
    word_d    = word_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rise) begin
          state_d   = S_HIGH;
          bit_idx_d = 1'b0;
        end
      end
      S_HIGH: begin
        if (fall) begin
          if ((cnt_q < HALF_U) || (cnt_q > FOUR_U)) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else if (bit_idx_q) begin
            word_d  = {shadow_q, pulse_bit};
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            shadow_d  = pulse_bit;
            bit_idx_d = 1'b1;
            cnt_d     = '0;
            state_d   = S_LOW;
          end
        end else if (cnt_q > FOUR_U) begin
          error_d = 1'b1;
          state_d = S_STUCK;
        end
      end
      S_LOW: begin
        if (rise) begin
          cnt_d   = '0;
          state_d = S_HIGH;
        end else if (cnt_q >= THREE_U) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_STUCK: begin
        if (fall) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter, shadow bit and registered outputs.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 1'b0;
      shadow_q  <= 1'b0;
      word_q    <= 2'b00;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shadow_q  <= shadow_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
    end
  end

  assign word  = word_q;
  assign valid = valid_q;
  assign error = error_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_receiveword.sv
// Bench for receiveword with UNIT_CYCLES=10. The whole input waveform is laid
// out as a per-cycle schedule, a pulse-level model derives the expected output
// waveform from it, and every cycle is compared, plus a few fixed expectations.
module tb_receiveword;

  localparam int U    = 10;
  localparam int MAXC = 2000;

  localparam int SIG_VALID = 0;
  localparam int SIG_ERROR = 1;
  localparam int SIG_BUSY  = 2;
  localparam int SIG_WORD  = 3;

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       in_line = 1'b1;
  logic [1:0] word;
  logic       valid, busy, error;

  receiveword #(.UNIT_CYCLES(U), .CNT_W(20)) dut (
    .sysclk(sysclk),
    .rst_n (rst_n),
    .in    (in_line),
    .word  (word),
    .valid (valid),
    .busy  (busy),
    .error (error)
  );

  always #5 sysclk = ~sysclk;

  bit       in_sched   [MAXC];
  bit       rstn_sched [MAXC];
  bit       exp_valid  [MAXC];
  bit       exp_error  [MAXC];
  bit       exp_busy   [MAXC];
  bit [1:0] exp_word   [MAXC];
  bit [1:0] vword      [MAXC];
  int       ncyc = 0;

  int lit_e   [64];
  int lit_sig [64];
  int lit_val [64];
  int nlit = 0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int cmp_e;
  bit running = 1'b0;

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic seg(input bit lvl, input int n, input bit rn = 1'b1);
    for (int i = 0; i < n; i++) begin
      in_sched[ncyc]   = lvl;
      rstn_sched[ncyc] = rn;
      ncyc++;
    end
  endtask

  task automatic lit(input int e, input int sig, input int val);
    lit_e[nlit]   = e;
    lit_sig[nlit] = sig;
    lit_val[nlit] = val;
    nlit++;
  endtask

  // Outputs sampled after edge e are in reset if rst_n was low at edge e or is
  // already low when the sample is taken.
  function automatic bit rst_at(input int e);
    if (e < 0) return 1'b1;
    if (!rstn_sched[e]) return 1'b1;
    if ((e + 1 < MAXC) && !rstn_sched[e+1]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit rst_in(input int a, input int b);
    for (int e = a; e <= b; e++) if (rst_at(e)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic fill_busy(input int a, input int b);
    for (int e = a; e <= b && e < MAXC; e++) begin
      if (rst_at(e)) break;
      exp_busy[e] = 1'b1;
    end
  endtask

  task automatic build();
    int r, f, ra;
    // reset with the line high
    seg(1, 5, 0); seg(0, 20);
    lit(3, SIG_WORD, 0); lit(4, SIG_BUSY, 0);
    // frame 01
    r = ncyc; seg(1, 10); seg(0, 10); seg(1, 30); f = ncyc; seg(0, 40);
    lit(r + 1, SIG_BUSY, 0); lit(r + 2, SIG_BUSY, 1);
    lit(f + 1, SIG_VALID, 0); lit(f + 2, SIG_VALID, 1); lit(f + 2, SIG_WORD, 1);
    lit(f + 3, SIG_VALID, 0); lit(f + 2, SIG_BUSY, 0);
    // frames 10 and 11 back to back
    seg(1, 30); seg(0, 10); seg(1, 10); f = ncyc; seg(0, 10);
    lit(f + 2, SIG_WORD, 2);
    seg(1, 30); seg(0, 10); seg(1, 30); f = ncyc; seg(0, 40);
    lit(f + 2, SIG_WORD, 3); lit(f + 2, SIG_VALID, 1);
    // glitch
    seg(1, 3); f = ncyc; seg(0, 30);
    lit(f + 2, SIG_ERROR, 1); lit(f + 2, SIG_WORD, 3); lit(f + 2, SIG_BUSY, 0);
    // gap timeout
    seg(1, 10); f = ncyc; seg(0, 45);
    lit(f + 32, SIG_ERROR, 0); lit(f + 32, SIG_BUSY, 1); lit(f + 33, SIG_ERROR, 1);
    // stuck high
    r = ncyc; seg(1, 60); seg(0, 30);
    lit(r + 43, SIG_ERROR, 0); lit(r + 44, SIG_ERROR, 1); lit(r + 45, SIG_ERROR, 0);
    lit(r + 55, SIG_BUSY, 1); lit(r + 62, SIG_BUSY, 0);
    // pulse widths near the class limits
    seg(1, 4); seg(0, 20);
    seg(1, 7); seg(0, 10); seg(1, 19); seg(0, 30);
    seg(1, 22); seg(0, 10); seg(1, 40); seg(0, 30);
    // one-cycle gap after a good frame, then after an error
    seg(1, 10); seg(0, 10); seg(1, 10); seg(0, 1);
    seg(1, 30); seg(0, 10); seg(1, 10); seg(0, 30);
    seg(1, 3); seg(0, 1); seg(1, 10); seg(0, 10); seg(1, 30); seg(0, 30);
    // reset during the second pulse, then a clean frame 00
    seg(1, 10); seg(0, 10); seg(1, 15); ra = ncyc; seg(0, 5, 0); seg(0, 10);
    lit(ra - 2, SIG_WORD, 1); lit(ra - 1, SIG_WORD, 0); lit(ra - 1, SIG_BUSY, 0);
    seg(1, 10); seg(0, 10); seg(1, 10); f = ncyc; seg(0, 30);
    lit(f + 2, SIG_VALID, 1); lit(f + 2, SIG_WORD, 0);
    seg(0, 20);
  endtask

  // Pulse-level model: each high run of N cycles measures N-1, outcomes land
  // two edges after the fall index (sync + detect), gaps are checked likewise.
  task automatic run_model();
    int t, n, c, nb, tf, lim;
    bit b0, bb;
    bit [1:0] w;
    nb = 0; tf = 0; b0 = 1'b0;
    t = 0;
    while (t < ncyc) begin
      if (!(in_sched[t] && (t == 0 || !in_sched[t-1]) && rstn_sched[t])) begin
        t++;
        continue;
      end
      n = 0;
      while ((t + n < ncyc) && in_sched[t+n] && rstn_sched[t+n]) n++;
      if (nb == 1) begin
        lim = (tf + 3*U + 3 < t + 1) ? tf + 3*U + 3 : t + 1;
        if (rst_in(tf, lim)) begin
          fill_busy(tf + 2, t + 1);
        end else if (t - tf >= 3*U + 2) begin
          fill_busy(tf + 2, tf + 3*U + 2);
          exp_error[tf + 3*U + 3] = 1'b1;
        end else begin
          fill_busy(tf + 2, t + 1);
        end
        if (rst_in(tf, lim) || (t - tf >= 3*U + 2)) nb = 0;
      end
      c = n - 1;
      fill_busy(t + 2, t + n + 1);
      if (rst_in(t, t + n + 2)) begin
        nb = 0;
      end else if (c > 4*U) begin
        exp_error[t + 4*U + 4] = 1'b1;
        nb = 0;
      end else if (c < U/2) begin
        exp_error[t + n + 2] = 1'b1;
        nb = 0;
      end else begin
        bb = (c >= 2*U);
        if (nb == 0) begin
          b0 = bb; nb = 1; tf = t + n;
        end else begin
          exp_valid[t + n + 2] = 1'b1;
          vword[t + n + 2] = {b0, bb};
          nb = 0;
        end
      end
      t = t + n;
    end
    if (nb == 1) begin
      fill_busy(tf + 2, tf + 3*U + 2);
      if (!rst_in(tf, tf + 3*U + 3)) exp_error[tf + 3*U + 3] = 1'b1;
    end
    w = 2'b00;
    for (int e = 0; e < MAXC; e++) begin
      if (rst_at(e)) w = 2'b00;
      else if (exp_valid[e]) w = vword[e];
      exp_word[e] = w;
    end
  endtask

  task automatic check(input string name, input int e, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, e, act, req);
    end
  endtask

  // Compare every cycle against the model, and the fixed expectations where due.
  always @(negedge sysclk) begin
    if (running && cyc >= 1 && cyc <= ncyc) begin
      cmp_e = cyc - 1;
      check("valid", cmp_e, {31'b0, valid}, {31'b0, exp_valid[cmp_e]});
      check("error", cmp_e, {31'b0, error}, {31'b0, exp_error[cmp_e]});
      check("busy",  cmp_e, {31'b0, busy},  {31'b0, exp_busy[cmp_e]});
      check("word",  cmp_e, {30'b0, word},  {30'b0, exp_word[cmp_e]});
      for (int i = 0; i < nlit; i++) begin
        if (lit_e[i] == cmp_e) begin
          case (lit_sig[i])
            SIG_VALID: check("lit_valid", cmp_e, {31'b0, valid}, lit_val[i]);
            SIG_ERROR: check("lit_error", cmp_e, {31'b0, error}, lit_val[i]);
            SIG_BUSY:  check("lit_busy",  cmp_e, {31'b0, busy},  lit_val[i]);
            default:   check("lit_word",  cmp_e, {30'b0, word},  lit_val[i]);
          endcase
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < MAXC; i++) begin
      in_sched[i]   = 1'b0;
      rstn_sched[i] = 1'b1;
      exp_valid[i]  = 1'b0;
      exp_error[i]  = 1'b0;
      exp_busy[i]   = 1'b0;
      exp_word[i]   = 2'b00;
      vword[i]      = 2'b00;
    end
    build();
    run_model();
    running = 1'b1;
    for (int t = 0; t < ncyc; t++) begin
      in_line = in_sched[t];
      rst_n   = rstn_sched[t];
      @(posedge sysclk);
      #1;
    end
    @(negedge sysclk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
